// File: rtl/fnd_display_arbiter_if.sv
// Request/display bundle between two requesters and the FND display arbiter.
interface fnd_display_arbiter_if;
  logic        req_a;
  logic [13:0] data_a;
  logic        ack_a;
  logic        req_b;
  logic [13:0] data_b;
  logic        ack_b;
  logic [13:0] disp_value;
  logic        disp_src;
  logic        disp_ovf;
  logic [1:0]  scan_sel;
  logic [3:0]  digit_mask;

  // Requester / environment side
  modport master (
    output req_a, data_a, req_b, data_b,
    input  ack_a, ack_b, disp_value, disp_src, disp_ovf, scan_sel, digit_mask
  );

  // Arbiter side
  modport slave (
    input  req_a, data_a, req_b, data_b,
    output ack_a, ack_b, disp_value, disp_src, disp_ovf, scan_sel, digit_mask
  );
endinterface

// File: rtl/fnd_display_arbiter.sv
// Two-requester round-robin arbiter for a 4-digit FND display.
// A grant lasts HOLD_TICKS scan ticks; the scan digit select free-runs on the tick.
module fnd_display_arbiter #(
  parameter int TICK_DIV   = 100000,
  parameter int HOLD_TICKS = 1000
) (
  input logic                 clk,
  input logic                 rst,
  fnd_display_arbiter_if.slave bus
);

  localparam int TW = (TICK_DIV   > 1) ? $clog2(TICK_DIV)   : 1;
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS - 1);
  localparam logic [13:0]   MAX_VAL   = 14'd9999;

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

  state_t      state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]  scan_q, scan_d;
  logic        rr_q, rr_d;          // last served: 0=A, 1=B
  logic [13:0] val_q, val_d;
  logic        src_q, src_d;
  logic        ovf_q, ovf_d;
  logic [3:0]  mask_q, mask_d;
  logic        ack_a_q, ack_a_d;
  logic        ack_b_q, ack_b_d;

  logic        tick;
  logic        grant_a, grant_b, refresh;
  logic        load, load_b;
  logic [13:0] raw;

  assign tick = (tick_cnt_q == TICK_LAST);

  // Tick divider and free-running digit scan, independent of arbitration
  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    scan_d     = tick ? scan_q + 2'd1 : scan_q;
  end

  // Arbitration FSM: next state, grant decisions and display data path
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rr_d    = rr_q;
    val_d   = val_q;
    src_d   = src_q;
    ovf_d   = ovf_q;
    ack_a_d = 1'b0;
    ack_b_d = 1'b0;
    grant_a = 1'b0;
    grant_b = 1'b0;
    refresh = 1'b0;
    raw     = '0;

    case (state_q)
      IDLE: begin
        if (bus.req_a && bus.req_b) begin
          grant_a = rr_q;
          grant_b = !rr_q;
        end else begin
          grant_a = bus.req_a;
          grant_b = bus.req_b;
        end
      end
      GRANT_A: begin
        if (tick && hold_q == '0) begin
          // Expiry: the other side gets priority, then the owner, else idle
          if (bus.req_b)      grant_b = 1'b1;
          else if (bus.req_a) grant_a = 1'b1;
          else                state_d = IDLE;
        end else begin
          if (tick) hold_d = hold_q - 1'b1;
          refresh = bus.req_a;
        end
      end
      GRANT_B: begin
        if (tick && hold_q == '0) begin
          if (bus.req_a)      grant_a = 1'b1;
          else if (bus.req_b) grant_b = 1'b1;
          else                state_d = IDLE;
        end else begin
          if (tick) hold_d = hold_q - 1'b1;
          refresh = bus.req_b;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_a) begin
      state_d = GRANT_A;
      hold_d  = HOLD_LOAD;
      rr_d    = 1'b0;
      src_d   = 1'b0;
      ack_a_d = 1'b1;
    end else if (grant_b) begin
      state_d = GRANT_B;
      hold_d  = HOLD_LOAD;
      rr_d    = 1'b1;
      src_d   = 1'b1;
      ack_b_d = 1'b1;
    end

    // A refresh always comes from the current owner; a grant from the new one
    load   = grant_a || grant_b || refresh;
    load_b = grant_b || (refresh && state_q == GRANT_B);
    raw    = load_b ? bus.data_b : bus.data_a;
    if (load) begin
      ovf_d = (raw > MAX_VAL);
      val_d = (raw > MAX_VAL) ? MAX_VAL : raw;
    end

    // Leading-zero blanking follows the value that will be shown next cycle
    if (state_d == IDLE) mask_d = 4'b0000;
    else mask_d = {val_d >= 14'd1000, val_d >= 14'd100, val_d >= 14'd10, 1'b1};
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      hold_q     <= '0;
      scan_q     <= '0;
      rr_q       <= 1'b1;   // pretend B was last so A wins the first tie
      val_q      <= '0;
      src_q      <= 1'b0;
      ovf_q      <= 1'b0;
      mask_q     <= '0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      hold_q     <= hold_d;
      scan_q     <= scan_d;
      rr_q       <= rr_d;
      val_q      <= val_d;
      src_q      <= src_d;
      ovf_q      <= ovf_d;
      mask_q     <= mask_d;
      ack_a_q    <= ack_a_d;
      ack_b_q    <= ack_b_d;
    end
  end

  assign bus.ack_a      = ack_a_q;
  assign bus.ack_b      = ack_b_q;
  assign bus.disp_value = val_q;
  assign bus.disp_src   = src_q;
  assign bus.disp_ovf   = ovf_q;
  assign bus.scan_sel   = scan_q;
  assign bus.digit_mask = mask_q;

endmodule

// File: tb/tb_fnd_display_arbiter.sv
// Self-checking bench for fnd_display_arbiter with a cycle-level behavioural model.
module tb_fnd_display_arbiter;
  localparam int TD = 4;
  localparam int HT = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fnd_display_arbiter_if bus();

  fnd_display_arbiter #(.TICK_DIV(TD), .HOLD_TICKS(HT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: phase within tick period, busy/owner, ticks left in the grant
  int   m_phase, m_scan, m_left, m_val;
  bit   m_busy, m_owner, m_last, m_src, m_ovf, m_acka, m_ackb;
  logic [3:0] m_mask;

  function automatic int clampv(int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  task automatic m_load(bit o);
    int raw;
    raw   = o ? int'(bus.data_b) : int'(bus.data_a);
    m_val = clampv(raw);
    m_ovf = (raw > 9999);
  endtask

  task automatic m_grant(bit o);
    m_busy = 1; m_owner = o; m_last = o; m_left = HT; m_src = o;
    if (o) m_ackb = 1; else m_acka = 1;
    m_load(o);
  endtask

  // Advance the model by one rising edge using the inputs now applied
  task automatic model_edge();
    bit tick, own_req, oth_req;
    if (!rst) begin
      m_phase = 0; m_scan = 0; m_left = 0; m_val = 0; m_busy = 0; m_owner = 0;
      m_last = 1; m_src = 0; m_ovf = 0; m_acka = 0; m_ackb = 0; m_mask = 4'b0000;
      return;
    end
    tick    = (m_phase == TD - 1);
    m_phase = (m_phase + 1) % TD;
    if (tick) m_scan = (m_scan + 1) % 4;
    m_acka = 0; m_ackb = 0;
    if (!m_busy) begin
      if (bus.req_a && bus.req_b) m_grant(!m_last);
      else if (bus.req_a)         m_grant(0);
      else if (bus.req_b)         m_grant(1);
    end else begin
      own_req = m_owner ? bus.req_b : bus.req_a;
      oth_req = m_owner ? bus.req_a : bus.req_b;
      if (tick && m_left == 1) begin
        if (oth_req)      m_grant(!m_owner);
        else if (own_req) m_grant(m_owner);
        else              m_busy = 0;
      end else begin
        if (tick) m_left--;
        if (own_req) m_load(m_owner);
      end
    end
    if (!m_busy) m_mask = 4'b0000;
    else m_mask = {m_val >= 1000, m_val >= 100, m_val >= 10, 1'b1};
  endtask

  function automatic logic [23:0] exp_vec();
    return {m_acka, m_ackb, m_src, m_ovf, 2'(m_scan), m_mask, 14'(m_val)};
  endfunction

  function automatic logic [23:0] obs_vec();
    return {bus.ack_a, bus.ack_b, bus.disp_src, bus.disp_ovf, bus.scan_sel,
            bus.digit_mask, bus.disp_value};
  endfunction

  // One clock: model the edge, let the DUT take it, settle past the edge
  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
  endtask

  task automatic set_req(bit a, int da, bit b, int db);
    bus.req_a = a; bus.data_a = 14'(da);
    bus.req_b = b; bus.data_b = 14'(db);
  endtask

  task automatic test_reset();
    set_req(0, 0, 0, 0);
    rst = 1'b0;
    repeat (3) cyc();
    n_chk++;
    if (obs_vec() !== 24'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want %h", obs_vec(), 24'h0);
    end
  endtask

  task automatic test_single_a();
    set_req(1, 42, 0, 0);
    do_reset();
    cyc();
    n_chk++;
    if (bus.ack_a !== 1'b1 || bus.ack_b !== 1'b0) begin
      n_fail++; $display("FAIL single_a_ack: got a=%b b=%b want a=1 b=0", bus.ack_a, bus.ack_b);
    end
    n_chk++;
    if (bus.disp_value !== 14'd42 || bus.disp_src !== 1'b0) begin
      n_fail++; $display("FAIL single_a_value: got %0d src %b want 42 src 0", bus.disp_value, bus.disp_src);
    end
    n_chk++;
    if (bus.digit_mask !== 4'b0011) begin
      n_fail++; $display("FAIL single_a_mask: got %b want 0011", bus.digit_mask);
    end
    cyc();
    n_chk++;
    if (bus.ack_a !== 1'b0) begin
      n_fail++; $display("FAIL single_a_ack_pulse: got %b want 0", bus.ack_a);
    end
  endtask

  task automatic test_tie();
    bit seen_b, seen_a2;
    logic [3:0] prev_mask;
    set_req(1, 5, 1, 600);
    do_reset();
    cyc();
    n_chk++;
    if (bus.ack_a !== 1'b1 || bus.disp_src !== 1'b0) begin
      n_fail++; $display("FAIL tie_first_a: got ack_a=%b src=%b want 1 0", bus.ack_a, bus.disp_src);
    end
    seen_b = 0; seen_a2 = 0;
    for (int i = 0; i < 60 && !seen_a2; i++) begin
      prev_mask = bus.digit_mask;
      cyc();
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL tie_model cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (bus.ack_b === 1'b1 && !seen_b) begin
        seen_b = 1;
        n_chk++;
        if (prev_mask === 4'b0000 || bus.disp_src !== 1'b1 || bus.disp_value !== 14'd600) begin
          n_fail++;
          $display("FAIL tie_direct_b: prev_mask %b src %b val %0d want nonzero 1 600",
                   prev_mask, bus.disp_src, bus.disp_value);
        end
      end else if (bus.ack_a === 1'b1 && seen_b) begin
        seen_a2 = 1;
      end
    end
    n_chk++;
    if (!(seen_b && seen_a2)) begin
      n_fail++; $display("FAIL tie_alternation: got seen_b=%b seen_a2=%b want 1 1", seen_b, seen_a2);
    end
  endtask

  task automatic test_clamp();
    set_req(0, 0, 1, 12000);
    do_reset();
    cyc();
    n_chk++;
    if (bus.disp_value !== 14'd9999 || bus.disp_ovf !== 1'b1) begin
      n_fail++; $display("FAIL clamp_value: got %0d ovf %b want 9999 ovf 1", bus.disp_value, bus.disp_ovf);
    end
    n_chk++;
    if (bus.digit_mask !== 4'b1111 || bus.ack_b !== 1'b1 || bus.disp_src !== 1'b1) begin
      n_fail++; $display("FAIL clamp_mask: got mask %b ack_b %b src %b want 1111 1 1",
                         bus.digit_mask, bus.ack_b, bus.disp_src);
    end
  endtask

  task automatic test_pulse();
    int granted;
    set_req(0, 0, 0, 0);
    do_reset();
    // Idle three cycles so the grant edge coincides with a tick: the grant
    // then spans exactly HT full tick periods.
    repeat (3) cyc();
    set_req(1, 7, 0, 0);
    cyc();
    set_req(0, 0, 0, 0);
    granted = (bus.digit_mask !== 4'b0000) ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL pulse_model cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (bus.digit_mask === 4'b0000) break;
      granted++;
    end
    n_chk++;
    if (granted != HT * TD) begin
      n_fail++; $display("FAIL pulse_hold_len: got %0d cycles want %0d", granted, HT * TD);
    end
    n_chk++;
    if (bus.digit_mask !== 4'b0000 || bus.disp_value !== 14'd7) begin
      n_fail++; $display("FAIL pulse_idle_retain: got mask %b val %0d want 0000 7",
                         bus.digit_mask, bus.disp_value);
    end
  endtask

  task automatic test_scan();
    int want;
    set_req(0, 0, 0, 0);
    do_reset();
    for (int k = 0; k < 20; k++) begin
      cyc();
      want = ((k + 1) / TD) % 4;
      n_chk++;
      if (int'(bus.scan_sel) != want) begin
        n_fail++; $display("FAIL scan_seq k=%0d: got %0d want %0d", k, bus.scan_sel, want);
      end
    end
  endtask

  task automatic test_mid_reset();
    set_req(1, 1234, 0, 0);
    do_reset();
    repeat (5) cyc();
    set_req(1, 1234, 1, 77);
    rst = 1'b0;
    cyc();
    n_chk++;
    if (obs_vec() !== 24'h0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got %h want %h", obs_vec(), 24'h0);
    end
    rst = 1'b1;
    cyc();
    n_chk++;
    if (bus.ack_a !== 1'b1 || bus.ack_b !== 1'b0 || bus.disp_value !== 14'd1234) begin
      n_fail++; $display("FAIL mid_reset_rearb: got a=%b b=%b val %0d want 1 0 1234",
                         bus.ack_a, bus.ack_b, bus.disp_value);
    end
  endtask

  task automatic test_random();
    set_req(0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) bus.req_a = ~bus.req_a;
      if ($urandom_range(0, 7) == 0) bus.req_b = ~bus.req_b;
      bus.data_a = 14'($urandom_range(0, 16383));
      bus.data_b = 14'($urandom_range(0, 16383));
      rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      cyc();
      n_chk++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      n_chk++;
      if (bus.ack_a === 1'b1 && bus.ack_b === 1'b1) begin
        n_fail++; $display("FAIL ack_exclusive cyc %0d: got both acks high want at most one", i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_tie();
    test_clamp();
    test_pulse();
    test_scan();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
